bcd_seq_converter: RTL and testbench

Sequential (shift-and-add-3) binary-to-BCD converter between the vending machine's 12-bit `money` output and the 7-segment driver's four BCD digit inputs. It converts one value over BIN_W clock cycles. This replaces the wide combinational add-3 array with one adjust stage and a small FSM. Digit outputs are registered and change only on completed conversions, so the display never shows partial results.

---
 rtl/bcd_seq_converter.sv | 126 ++++++++++++
 tb/tb_bcd_seq_converter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter.
// Converts one BIN_W-bit value over BIN_W shift cycles. Digit outputs are
// registered and update only when a conversion completes.
module bcd_seq_converter #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic [3:0]       thos,
  output logic [3:0]       huns,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             busy,
  output logic             valid
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Add 3 to every nibble that is 5 or more, all nibbles in parallel.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   last_bin_q, last_bin_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               valid_q, valid_d;

  logic               capture;
  logic               last_shift;
  logic [SR_W-1:0]    shifted;

  // Conversion trigger and final-shift detection.
  always_comb begin
    capture    = (state_q == IDLE) && ((bin != last_bin_q) || start);
    last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(BIN_W - 1));
    shifted    = {add3_adjust(bcd_sr_q), bin_sr_q} << 1;
  end

  // State register and datapath registers; async active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_bin_q <= '0;
      bin_sr_q   <= '0;
      bcd_sr_q   <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_bin_q <= last_bin_d;
      bin_sr_q   <= bin_sr_d;
      bcd_sr_q   <= bcd_sr_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: leave IDLE on a new value or start, return after the last shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)    state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath next values: capture in IDLE, adjust-then-shift in SHIFT.
  always_comb begin
    last_bin_d = last_bin_q;
    bin_sr_d   = bin_sr_q;
    bcd_sr_d   = bcd_sr_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    valid_d    = 1'b0;
    if (capture) begin
      bin_sr_d   = bin;
      last_bin_d = bin;
      bcd_sr_d   = '0;
      cnt_d      = '0;
    end else if (state_q == SHIFT) begin
      bcd_sr_d = shifted[SR_W-1:BIN_W];
      bin_sr_d = shifted[BIN_W-1:0];
      cnt_d    = cnt_q + 1'b1;
      if (last_shift) begin
        // Publish the post-shift accumulator; the display never sees partial sums.
        digits_d = shifted[SR_W-1:BIN_W];
        valid_d  = 1'b1;
      end
    end
  end

  // Outputs: busy follows the FSM, digits and valid come straight from flops.
  always_comb begin
    busy  = (state_q == SHIFT);
    valid = valid_q;
    thos  = digits_q[12 +: 4];
    huns  = digits_q[8 +: 4];
    tens  = digits_q[4 +: 4];
    ones  = digits_q[0 +: 4];
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Testbench for bcd_seq_converter: directed and randomized conversions
// checked against decimal arithmetic and the fixed 13-edge timing.
module tb_bcd_seq_converter;

  logic        clk;
  logic        reset;
  logic [11:0] bin;
  logic        start;
  logic [3:0]  thos, huns, tens, ones;
  logic        busy;
  logic        valid;

  int checks   = 0;
  int failures = 0;
  int shown    = 0;   // value the display should currently show

  bcd_seq_converter #(.BIN_W(12), .DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bin   (bin),
    .start (start),
    .thos  (thos),
    .huns  (huns),
    .tens  (tens),
    .ones  (ones),
    .busy  (busy),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dec_digits(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((v / 1000) % 10);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int val);
    chk({tag, "_digits"}, {thos, huns, tens, ones}, dec_digits(val));
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_valid"}, {15'd0, valid}, 16'd0);
  endtask

  // Called at a negedge with bin/start already set so that the next posedge captures.
  // change_at / start_at: shift cycle index at which bin changes / start is raised (-1 = never).
  task automatic expect_conv(input int val, input int change_at, input int new_bin,
                             input int start_at, input string tag);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
      chk({tag, "_valid_lo"}, {15'd0, valid}, 16'd0);
      chk({tag, "_hold"}, {thos, huns, tens, ones}, dec_digits(shown));
      if (k == change_at) bin = 12'(new_bin);
      start = (k == start_at);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_valid"}, {15'd0, valid}, 16'd1);
    chk({tag, "_digits"}, {thos, huns, tens, ones}, dec_digits(val));
    shown = val;
  endtask

  initial begin
    int v, nb, chg;
    reset = 1'b0;
    bin   = 12'd0;
    start = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle_outputs("quiet", 0);
    end

    // Maximum value
    bin = 12'd4095;
    expect_conv(4095, -1, 0, -1, "max");

    // Boundaries back-to-back
    bin = 12'd999;  expect_conv(999,  -1, 0, -1, "b999");
    bin = 12'd1000; expect_conv(1000, -1, 0, -1, "b1000");
    bin = 12'd5;    expect_conv(5,    -1, 0, -1, "b5");
    bin = 12'd0;    expect_conv(0,    -1, 0, -1, "b0");

    // Input change during conversion, then automatic recapture
    bin = 12'd4095;
    expect_conv(4095, 4, 25, -1, "chg_first");
    expect_conv(25, -1, 0, -1, "chg_recap");

    // Start with unchanged value, plus a start pulse during SHIFT that must be ignored
    bin = 12'd250;  expect_conv(250, -1, 0, -1, "s250");
    start = 1'b1;   expect_conv(250, -1, 0, 5, "start");
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk_idle_outputs("no_extra", 250);
    end

    // Reset during conversion of 1234
    bin = 12'd1234;
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    reset = 1'b0;
    #1;
    chk_idle_outputs("midrst", 0);
    @(negedge clk);
    chk_idle_outputs("midrst_hold", 0);
    reset = 1'b1;
    shown = 0;
    expect_conv(1234, -1, 0, -1, "rst_recap");

    // Randomized conversions, some with a mid-conversion input change
    for (int n = 0; n < 10; n++) begin
      v = int'($urandom_range(0, 4095));
      if (v == shown) start = 1'b1;
      bin = 12'(v);
      if ($urandom_range(0, 1) == 1) begin
        chg = int'($urandom_range(0, 10));
        nb  = (v + 1 + int'($urandom_range(0, 4094))) % 4096;
        expect_conv(v, chg, nb, -1, "rnd_a");
        expect_conv(nb, -1, 0, -1, "rnd_b");
      end else begin
        expect_conv(v, -1, 0, -1, "rnd");
      end
    end

    @(negedge clk);
    chk_idle_outputs("final", shown);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
